// File: rtl/mux_ff_chk_pkg.sv
// Shared types and helpers for the registered 2:1 mux flip-flop response checker.
package mux_ff_chk_pkg;

  typedef enum logic [1:0] {IDLE, WARMUP, CHECK, FAIL} chk_state_t;

  // Saturating increment; callers pass the all-ones value of their own counter width.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
    return (cnt >= max) ? max : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/mux_ff_ref_model.sv
// One-cycle reference model of the mux flip-flop: predicts q for the next edge.
module mux_ff_ref_model #(
  parameter bit INVERT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic clr_vld,
  input  logic dut_rst_n,
  input  logic A,
  input  logic B,
  input  logic S,
  output logic exp_q,
  output logic model_vld
);

  logic exp_d;

  // A DUT held in reset drives 0 regardless of INVERT.
  always_comb begin
    exp_d = 1'b0;
    if (dut_rst_n) begin
      exp_d = INVERT ^ (S ? A : B);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q     <= 1'b0;
      model_vld <= 1'b0;
    end else if (load) begin
      exp_q     <= exp_d;
      model_vld <= ~clr_vld;
    end
  end

endmodule

// File: rtl/mux_ff_checker.sv
// Response checker for the registered 2:1 mux flip-flop: counts checks and mismatches,
// records the first failing check index and raises a sticky fail flag.
module mux_ff_checker
  import mux_ff_chk_pkg::*;
#(
  parameter int unsigned CNT_W        = 8,
  parameter bit          INVERT       = 1'b0,
  parameter bit          STOP_ON_FAIL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dut_rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             S,
  input  logic             q,
  output logic [CNT_W-1:0] checked_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic             fail,
  output logic             busy
);

  localparam logic [31:0] CntMax = 32'((64'd1 << CNT_W) - 64'd1);

  chk_state_t state_q, state_d;

  logic [CNT_W-1:0] checked_q, checked_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic             fail_q, fail_d;

  logic exp_q;
  logic model_vld;
  logic do_cmp;
  logic mismatch;

  mux_ff_ref_model #(
    .INVERT(INVERT)
  ) u_ref (
    .clk      (clk),
    .rst      (rst),
    .load     (state_q != FAIL),
    .clr_vld  (state_q == IDLE),
    .dut_rst_n(dut_rst_n),
    .A        (A),
    .B        (B),
    .S        (S),
    .exp_q    (exp_q),
    .model_vld(model_vld)
  );

  assign do_cmp   = (state_q == CHECK) && model_vld;
  assign mismatch = do_cmp && (q != exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = WARMUP;
      WARMUP:  state_d = en ? CHECK : IDLE;
      CHECK: begin
        if (mismatch && STOP_ON_FAIL) begin
          state_d = FAIL;
        end else if (!en) begin
          state_d = IDLE;
        end
      end
      FAIL:    state_d = FAIL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CHECK);
  end

  // first_err_idx takes the pre-increment check index of the first mismatch.
  always_comb begin
    checked_d = checked_q;
    err_d     = err_q;
    first_d   = first_q;
    fail_d    = fail_q;
    if (do_cmp) begin
      checked_d = CNT_W'(sat_inc(32'(checked_q), CntMax));
      if (mismatch) begin
        err_d  = CNT_W'(sat_inc(32'(err_q), CntMax));
        fail_d = 1'b1;
        if (!fail_q) begin
          first_d = checked_q;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      checked_q <= '0;
      err_q     <= '0;
      first_q   <= '0;
      fail_q    <= 1'b0;
    end else begin
      checked_q <= checked_d;
      err_q     <= err_d;
      first_q   <= first_d;
      fail_q    <= fail_d;
    end
  end

  assign checked_cnt   = checked_q;
  assign err_cnt       = err_q;
  assign first_err_idx = first_q;
  assign fail          = fail_q;

endmodule

// File: tb/tb_mux_ff_checker.sv
// Bench for mux_ff_checker: six checker variants watch a good, a stuck-at-0 and an
// inverted mux flip-flop, scored against a cycle model plus hand-computed expectations.
module tb_mux_ff_checker;

  localparam int N = 6;

  logic clk = 1'b0;
  logic rst, en, dut_rst_n, a_in, b_in, s_in;
  logic good_q;
  logic zero_q;
  logic inv_q;

  logic [7:0] cc[N], ec[N], fi[N];
  logic       fl[N], bz[N];
  logic [2:0] cc3, ec3, fi3, cc5, ec5, fi5;

  int n_cmp = 0;
  int n_err = 0;

  // Per-instance setup: 0 good, 1 stuck, 2 stuck+stop, 3 good CNT_W=3, 4 inverted, 5 stuck CNT_W=3
  bit fault_c[N] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  bit inv_c[N]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  bit stop_c[N]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  int maxv_c[N]  = '{255, 255, 255, 7, 255, 7};

  always #5 clk = ~clk;

  // Reference mux flip-flops driven with the same stimulus.
  always_ff @(posedge clk) begin
    if (!dut_rst_n) good_q <= 1'b0;
    else            good_q <= s_in ? a_in : b_in;
  end
  assign zero_q = 1'b0;
  assign inv_q  = ~good_q;

  mux_ff_checker #(.CNT_W(8), .INVERT(1'b0), .STOP_ON_FAIL(1'b0)) u0 (
    .clk(clk), .rst(rst), .en(en), .dut_rst_n(dut_rst_n), .A(a_in), .B(b_in), .S(s_in),
    .q(good_q), .checked_cnt(cc[0]), .err_cnt(ec[0]), .first_err_idx(fi[0]), .fail(fl[0]),
    .busy(bz[0]));
  mux_ff_checker #(.CNT_W(8), .INVERT(1'b0), .STOP_ON_FAIL(1'b0)) u1 (
    .clk(clk), .rst(rst), .en(en), .dut_rst_n(dut_rst_n), .A(a_in), .B(b_in), .S(s_in),
    .q(zero_q), .checked_cnt(cc[1]), .err_cnt(ec[1]), .first_err_idx(fi[1]), .fail(fl[1]),
    .busy(bz[1]));
  mux_ff_checker #(.CNT_W(8), .INVERT(1'b0), .STOP_ON_FAIL(1'b1)) u2 (
    .clk(clk), .rst(rst), .en(en), .dut_rst_n(dut_rst_n), .A(a_in), .B(b_in), .S(s_in),
    .q(zero_q), .checked_cnt(cc[2]), .err_cnt(ec[2]), .first_err_idx(fi[2]), .fail(fl[2]),
    .busy(bz[2]));
  mux_ff_checker #(.CNT_W(3), .INVERT(1'b0), .STOP_ON_FAIL(1'b0)) u3 (
    .clk(clk), .rst(rst), .en(en), .dut_rst_n(dut_rst_n), .A(a_in), .B(b_in), .S(s_in),
    .q(good_q), .checked_cnt(cc3), .err_cnt(ec3), .first_err_idx(fi3), .fail(fl[3]),
    .busy(bz[3]));
  mux_ff_checker #(.CNT_W(8), .INVERT(1'b1), .STOP_ON_FAIL(1'b0)) u4 (
    .clk(clk), .rst(rst), .en(en), .dut_rst_n(dut_rst_n), .A(a_in), .B(b_in), .S(s_in),
    .q(inv_q), .checked_cnt(cc[4]), .err_cnt(ec[4]), .first_err_idx(fi[4]), .fail(fl[4]),
    .busy(bz[4]));
  mux_ff_checker #(.CNT_W(3), .INVERT(1'b0), .STOP_ON_FAIL(1'b0)) u5 (
    .clk(clk), .rst(rst), .en(en), .dut_rst_n(dut_rst_n), .A(a_in), .B(b_in), .S(s_in),
    .q(zero_q), .checked_cnt(cc5), .err_cnt(ec5), .first_err_idx(fi5), .fail(fl[5]),
    .busy(bz[5]));

  assign cc[3] = {5'b0, cc3};
  assign ec[3] = {5'b0, ec3};
  assign fi[3] = {5'b0, fi3};
  assign cc[5] = {5'b0, cc5};
  assign ec[5] = {5'b0, ec5};
  assign fi[5] = {5'b0, fi5};

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 warm-up, 2 checking, 3 frozen after a stop.
  int  ph[N], m_cnt[N], m_err[N], m_fidx[N];
  bit  m_fail[N];
  bit  prev_rstn, prev_mux, model_on = 1'b0;

  always @(posedge clk) begin
    bit exp_v, good_v, seen_v, mism;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        ph[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_fidx[i] = 0; m_fail[i] = 1'b0;
      end
    end else if (model_on) begin
      for (int i = 0; i < N; i++) begin
        case (ph[i])
          0: if (en) ph[i] = 1;
          1: ph[i] = en ? 2 : 0;
          2: begin
            good_v = prev_rstn ? prev_mux : 1'b0;
            exp_v  = prev_rstn ? (inv_c[i] ^ prev_mux) : 1'b0;
            seen_v = fault_c[i] ? 1'b0 : (inv_c[i] ? ~good_v : good_v);
            mism   = (seen_v != exp_v);
            if (mism) begin
              if (!m_fail[i]) m_fidx[i] = m_cnt[i];
              m_fail[i] = 1'b1;
              if (m_err[i] < maxv_c[i]) m_err[i]++;
            end
            if (m_cnt[i] < maxv_c[i]) m_cnt[i]++;
            if (mism && stop_c[i]) ph[i] = 3;
            else if (!en)          ph[i] = 0;
          end
          default: ;
        endcase
      end
    end
    if (rst) model_on = 1'b1;
    prev_rstn = dut_rst_n;
    prev_mux  = s_in ? a_in : b_in;
  end

  always @(negedge clk) begin
    if (model_on) begin
      for (int i = 0; i < N; i++) begin
        chk($sformatf("u%0d checked_cnt", i), int'(cc[i]), m_cnt[i]);
        chk($sformatf("u%0d err_cnt", i), int'(ec[i]), m_err[i]);
        chk($sformatf("u%0d first_err_idx", i), int'(fi[i]), m_fidx[i]);
        chk($sformatf("u%0d fail", i), int'(fl[i]), int'(m_fail[i]));
        chk($sformatf("u%0d busy", i), int'(bz[i]), int'(ph[i] == 2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_abs(input logic [2:0] v);
    {a_in, b_in, s_in} = v;
  endtask

  logic [2:0] tbl[12] = '{3'b101, 3'b110, 3'b011, 3'b000, 3'b111, 3'b100,
                          3'b101, 3'b010, 3'b001, 3'b111, 3'b101, 3'b110};

  initial begin
    rst = 1'b1; en = 1'b0; dut_rst_n = 1'b0; set_abs(3'b000);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("reset u0 checked_cnt", int'(cc[0]), 0);
    chk("reset u0 err_cnt", int'(ec[0]), 0);
    chk("reset u0 first_err_idx", int'(fi[0]), 0);
    chk("reset u0 fail", int'(fl[0]), 0);
    chk("reset u0 busy", int'(bz[0]), 0);

    // DUT reset for three edges, then the four directed vectors; en falls for the last compare.
    en = 1'b1;
    tick();
    chk("warmup u0 busy", int'(bz[0]), 0);
    tick();
    chk("check u0 busy", int'(bz[0]), 1);
    tick();
    chk("first compare u0 checked_cnt", int'(cc[0]), 1);
    dut_rst_n = 1'b1;
    set_abs(3'b101); tick();
    set_abs(3'b110); tick();
    chk("stop u2 busy after first error", int'(bz[2]), 0);
    chk("stop u2 fail", int'(fl[2]), 1);
    set_abs(3'b011); tick();
    set_abs(3'b000); tick();
    en = 1'b0; tick();
    chk("good u0 checked_cnt", int'(cc[0]), 6);
    chk("good u0 err_cnt", int'(ec[0]), 0);
    chk("good u0 fail", int'(fl[0]), 0);
    chk("good u0 busy after en drop", int'(bz[0]), 0);
    chk("stuck u1 fail", int'(fl[1]), 1);
    chk("stuck u1 first_err_idx", int'(fi[1]), 2);
    chk("stuck u1 err_cnt", int'(ec[1]), 2);
    chk("stop u2 checked_cnt", int'(cc[2]), 3);
    chk("stop u2 err_cnt", int'(ec[2]), 1);
    chk("inv u4 err_cnt", int'(ec[4]), 2);
    chk("inv u4 first_err_idx", int'(fi[4]), 0);

    // Second idle cycle, then re-arm: exactly one warm-up cycle with no compare.
    tick();
    en = 1'b1; set_abs(3'b101);
    tick();
    chk("rearm idle->warmup u0 checked_cnt", int'(cc[0]), 6);
    chk("rearm idle->warmup u0 busy", int'(bz[0]), 0);
    tick();
    chk("rearm warmup u0 checked_cnt", int'(cc[0]), 6);
    chk("rearm warmup u0 busy", int'(bz[0]), 1);
    for (int k = 0; k < 12; k++) begin
      set_abs(tbl[k]);
      tick();
      if (k == 0) chk("resume u0 checked_cnt", int'(cc[0]), 7);
    end
    chk("long u0 checked_cnt", int'(cc[0]), 18);
    chk("sat u3 checked_cnt", int'(cc[3]), 7);
    chk("sat u3 err_cnt", int'(ec[3]), 0);
    chk("sat u5 err_cnt", int'(ec[5]), 7);
    chk("sat u5 fail", int'(fl[5]), 1);
    chk("frozen u2 checked_cnt", int'(cc[2]), 3);
    chk("frozen u2 err_cnt", int'(ec[2]), 1);
    chk("frozen u2 busy", int'(bz[2]), 0);

    // Checker reset while checking clears everything on that edge.
    rst = 1'b1; tick();
    chk("midrst u0 checked_cnt", int'(cc[0]), 0);
    chk("midrst u0 busy", int'(bz[0]), 0);
    chk("midrst u1 err_cnt", int'(ec[1]), 0);
    chk("midrst u1 fail", int'(fl[1]), 0);
    chk("midrst u2 checked_cnt", int'(cc[2]), 0);
    chk("midrst u2 fail", int'(fl[2]), 0);
    rst = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_abs(tbl[k + 3]);
      if (k == 4) dut_rst_n = 1'b0;
      tick();
    end
    en = 1'b0; tick(); tick();
    chk("rerun u0 checked_cnt", int'(cc[0]), 5);
    chk("rerun u0 err_cnt", int'(ec[0]), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
